// File: rtl/wb_gp_arbiter.sv
// Purpose: shares the GP register-file write port between WB (fixed priority) and a FIFO of aux results.
// Latency: an aux result is written 1 cycle after accept when the FIFO is empty and WB is idle.
// Backpressure: aux_ready drops when the FIFO is full; with AMBER_WBARB_FAIR_EN a starved head stalls WB for one cycle.
module wb_gp_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int SIZE_TGT_GP  = 5,
   parameter int SIZE_DATA    = 32
) (
   input  logic                     iw_clk,
   input  logic                     iw_rst,
   input  logic                     iw_pipe_we,
   input  logic [SIZE_TGT_GP-1:0]   iw_pipe_addr,
   input  logic [SIZE_DATA-1:0]     iw_pipe_data,
   input  logic                     iw_aux_valid,
   output logic                     ow_aux_ready,
   input  logic [SIZE_TGT_GP-1:0]   iw_aux_addr,
   input  logic [SIZE_DATA-1:0]     iw_aux_data,
   output logic                     ow_gp_write_enable,
   output logic [SIZE_TGT_GP-1:0]   ow_gp_write_addr,
   output logic [SIZE_DATA-1:0]     ow_gp_write_data,
   output logic                     ow_pipe_stall,
   output logic [$clog2(DEPTH):0]   ow_pend_count,
   output logic                     ow_aux_granted
);

   localparam int PW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
      $error("wb_gp_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
   end

   logic [SIZE_TGT_GP-1:0] fifo_addr [DEPTH];
   logic [SIZE_DATA-1:0]   fifo_data [DEPTH];
   logic [DEPTH-1:0]       fifo_vld;
   logic [DEPTH-1:0]       vld_nxt;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [PW:0]            count;
   logic                   full;
   logic                   empty;
   logic                   head_vld;
   logic                   wb_win;
   logic                   push;
   logic                   pop;
   logic                   grant;
   logic                   stall;

   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign head_vld = fifo_vld[rd_ptr];
   // A stalled WB request neither writes nor kills; it is replayed next cycle.
   assign wb_win   = iw_pipe_we & ~stall;
   assign push     = iw_aux_valid & ~full;
   // Killed heads pop without writing, so pop does not depend on head_vld.
   assign pop      = ~wb_win & ~empty;
   assign grant    = pop & head_vld;

`ifdef AMBER_WBARB_FAIR_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] starve_cnt;

   assign stall = ~empty & head_vld & (starve_cnt == CW'(STARVE_LIMIT));

   // Count cycles a valid head loses to WB; clear whenever the head drains or the FIFO empties.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         starve_cnt <= '0;
      end else if (empty || grant) begin
         starve_cnt <= '0;
      end else if (head_vld && iw_pipe_we) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign stall = 1'b0;
`endif

   // Valid-bit next state: WB address match kills, pop clears the head slot, push marks the new slot valid.
   always_comb begin
      vld_nxt = fifo_vld;
      if (wb_win) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (fifo_addr[i] == iw_pipe_addr) vld_nxt[i] = 1'b0;
         end
      end
      if (pop)  vld_nxt[rd_ptr] = 1'b0;
      // Applied last: an entry accepted this cycle is younger than the WB write.
      if (push) vld_nxt[wr_ptr] = 1'b1;
   end

   // FIFO control state: pointers, occupancy and per-slot valid bits.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         fifo_vld <= '0;
      end else begin
         fifo_vld <= vld_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage; captured only on accept, qualified by fifo_vld so no reset is needed.
   always_ff @(posedge iw_clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= iw_aux_addr;
         fifo_data[wr_ptr] <= iw_aux_data;
      end
   end

   // Write-port mux: WB first, then a valid aux head, otherwise idle with zeroed address/data.
   always_comb begin
      ow_gp_write_enable = 1'b0;
      ow_gp_write_addr   = '0;
      ow_gp_write_data   = '0;
      ow_aux_granted     = 1'b0;
      if (wb_win) begin
         ow_gp_write_enable = 1'b1;
         ow_gp_write_addr   = iw_pipe_addr;
         ow_gp_write_data   = iw_pipe_data;
      end else if (grant) begin
         ow_gp_write_enable = 1'b1;
         ow_gp_write_addr   = fifo_addr[rd_ptr];
         ow_gp_write_data   = fifo_data[rd_ptr];
         ow_aux_granted     = 1'b1;
      end
   end

   assign ow_aux_ready  = ~full;
   assign ow_pend_count = count;
   assign ow_pipe_stall = stall;

endmodule

// File: tb/tb_wb_gp_arbiter.sv
// Directed bench for wb_gp_arbiter: stimulus queues expected writes, a negedge monitor pops and compares.
// Expected WB writes and aux writes are kept in separate queues in issue order.
// Occupancy, ready and stall are checked against hand-computed values.
module tb_wb_gp_arbiter;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        iw_clk;
   logic        iw_rst;
   logic        iw_pipe_we;
   logic [4:0]  iw_pipe_addr;
   logic [31:0] iw_pipe_data;
   logic        iw_aux_valid;
   logic        ow_aux_ready;
   logic [4:0]  iw_aux_addr;
   logic [31:0] iw_aux_data;
   logic        ow_gp_write_enable;
   logic [4:0]  ow_gp_write_addr;
   logic [31:0] ow_gp_write_data;
   logic        ow_pipe_stall;
   logic [2:0]  ow_pend_count;
   logic        ow_aux_granted;

   wr_t wb_q[$];
   wr_t aux_q[$];
   wr_t mon_e;
   int  n_cmp = 0;
   int  n_err = 0;

   wb_gp_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .SIZE_TGT_GP(5), .SIZE_DATA(32)) dut (
      .iw_clk             (iw_clk),
      .iw_rst             (iw_rst),
      .iw_pipe_we         (iw_pipe_we),
      .iw_pipe_addr       (iw_pipe_addr),
      .iw_pipe_data       (iw_pipe_data),
      .iw_aux_valid       (iw_aux_valid),
      .ow_aux_ready       (ow_aux_ready),
      .iw_aux_addr        (iw_aux_addr),
      .iw_aux_data        (iw_aux_data),
      .ow_gp_write_enable (ow_gp_write_enable),
      .ow_gp_write_addr   (ow_gp_write_addr),
      .ow_gp_write_data   (ow_gp_write_data),
      .ow_pipe_stall      (ow_pipe_stall),
      .ow_pend_count      (ow_pend_count),
      .ow_aux_granted     (ow_aux_granted)
   );

   initial iw_clk = 1'b0;
   always #5 iw_clk = ~iw_clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge iw_clk);
      #1;
   endtask

   task automatic wb_set(input int we, input int a, input int d);
      iw_pipe_we   = (we != 0);
      iw_pipe_addr = 5'(a);
      iw_pipe_data = 32'(d);
      if (we != 0) wb_q.push_back(wr_t'{5'(a), 32'(d)});
   endtask

   task automatic aux_set(input int v, input int a, input int d);
      iw_aux_valid = (v != 0);
      iw_aux_addr  = 5'(a);
      iw_aux_data  = 32'(d);
   endtask

   // Monitor: every register-file write must match the head of the matching expectation queue.
   always @(negedge iw_clk) begin
      if (!iw_rst && ow_gp_write_enable) begin
         if (ow_aux_granted) begin
            if (aux_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_aux_write: got addr %0d data 0x%0h, required none", ow_gp_write_addr, ow_gp_write_data);
            end else begin
               mon_e = aux_q.pop_front();
               check("aux_wr_addr", 32'(ow_gp_write_addr), 32'(mon_e.a));
               check("aux_wr_data", ow_gp_write_data, mon_e.d);
            end
         end else begin
            if (wb_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_wb_write: got addr %0d data 0x%0h, required none", ow_gp_write_addr, ow_gp_write_data);
            end else begin
               mon_e = wb_q.pop_front();
               check("wb_wr_addr", 32'(ow_gp_write_addr), 32'(mon_e.a));
               check("wb_wr_data", ow_gp_write_data, mon_e.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_cnt;
      int n;
      bit acc;
      bit pp;

      iw_rst = 1'b1;
      wb_set(0, 0, 0);
      aux_set(0, 0, 0);
      repeat (2) @(posedge iw_clk);
      @(negedge iw_clk);
      check("rst_ready", 32'(ow_aux_ready), 32'd1);
      check("rst_we",    32'(ow_gp_write_enable), 32'd0);
      check("rst_addr",  32'(ow_gp_write_addr), 32'd0);
      check("rst_data",  ow_gp_write_data, 32'd0);
      check("rst_stall", 32'(ow_pipe_stall), 32'd0);
      check("rst_pend",  32'(ow_pend_count), 32'd0);
      check("rst_grant", 32'(ow_aux_granted), 32'd0);
      nxt();
      iw_rst = 1'b0;

      // Single aux push with WB idle: written the next cycle.
      aux_set(1, 3, 32'h1234);
      aux_q.push_back(wr_t'{5'd3, 32'h1234});
      @(negedge iw_clk);
      check("t1_pend0", 32'(ow_pend_count), 32'd0);
      nxt();
      aux_set(0, 0, 0);
      @(negedge iw_clk);
      check("t1_pend1", 32'(ow_pend_count), 32'd1);
      check("t1_grant", 32'(ow_aux_granted), 32'd1);
      nxt();
      @(negedge iw_clk);
      check("t1_pend_drained", 32'(ow_pend_count), 32'd0);
      check("t1_idle_we", 32'(ow_gp_write_enable), 32'd0);
      nxt();

      // WB busy for 6 cycles while 4 aux entries fill the FIFO, then drain in order.
      for (int i = 0; i < 6; i++) begin
         wb_set(1, 10 + i, 32'h100 + i);
         if (i < 4) begin
            aux_set(1, 20 + i, 32'h200 + i);
            aux_q.push_back(wr_t'{5'(20 + i), 32'(32'h200 + i)});
         end else begin
            aux_set(0, 0, 0);
         end
         @(negedge iw_clk);
         check("t2_ready", 32'(ow_aux_ready), (i < 4) ? 32'd1 : 32'd0);
         check("t2_pend",  32'(ow_pend_count), (i < 4) ? 32'(i) : 32'd4);
         nxt();
      end
      wb_set(0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge iw_clk);
         check("t2_drain_pend", 32'(ow_pend_count), 32'(4 - k));
         nxt();
      end
      @(negedge iw_clk);
      check("t2_empty", 32'(ow_pend_count), 32'd0);
      nxt();

      // Queued aux r5 is killed by a later WB write to r5.
      wb_set(1, 9, 9);
      aux_set(1, 5, 32'hAAAA);
      @(negedge iw_clk);
      nxt();
      wb_set(1, 5, 32'hBBBB);
      aux_set(0, 0, 0);
      @(negedge iw_clk);
      check("t3_pend_blocked", 32'(ow_pend_count), 32'd1);
      nxt();
      wb_set(0, 0, 0);
      @(negedge iw_clk);
      check("t3_kill_pend", 32'(ow_pend_count), 32'd1);
      check("t3_kill_we",   32'(ow_gp_write_enable), 32'd0);
      check("t3_kill_grant", 32'(ow_aux_granted), 32'd0);
      nxt();
      @(negedge iw_clk);
      check("t3_pend_after", 32'(ow_pend_count), 32'd0);
      nxt();

      // Same-cycle aux push and WB write to r7: aux survives and writes after.
      wb_set(1, 7, 32'h7070);
      aux_set(1, 7, 32'h7777);
      aux_q.push_back(wr_t'{5'd7, 32'h7777});
      @(negedge iw_clk);
      nxt();
      wb_set(0, 0, 0);
      aux_set(0, 0, 0);
      @(negedge iw_clk);
      check("t4_pend", 32'(ow_pend_count), 32'd1);
      check("t4_grant", 32'(ow_aux_granted), 32'd1);
      nxt();
      @(negedge iw_clk);
      check("t4_empty", 32'(ow_pend_count), 32'd0);
      nxt();

      // Fill to full, then 20 cycles of continuous producer with drain across pointer wrap.
      exp_cnt = 0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         wb_set(1, 1, 32'h400 + i);
         aux_set(1, 16 + (n % 8), 32'h300 + n);
         aux_q.push_back(wr_t'{5'(16 + (n % 8)), 32'(32'h300 + n)});
         n++;
         exp_cnt++;
         @(negedge iw_clk);
         nxt();
      end
      wb_set(0, 0, 0);
      for (int c = 0; c < 20; c++) begin
         aux_set(1, 16 + (n % 8), 32'h300 + n);
         @(negedge iw_clk);
         check("t5_ready", 32'(ow_aux_ready), (exp_cnt < 4) ? 32'd1 : 32'd0);
         check("t5_pend",  32'(ow_pend_count), 32'(exp_cnt));
         acc = (exp_cnt < 4);
         pp  = (exp_cnt > 0);
         if (acc) begin
            aux_q.push_back(wr_t'{5'(16 + (n % 8)), 32'(32'h300 + n)});
            n++;
         end
         exp_cnt = exp_cnt + int'(acc) - int'(pp);
         nxt();
      end
      aux_set(0, 0, 0);
      for (int c = 0; c < 8 && exp_cnt > 0; c++) begin
         @(negedge iw_clk);
         check("t5_drain_pend", 32'(ow_pend_count), 32'(exp_cnt));
         exp_cnt--;
         nxt();
      end
      @(negedge iw_clk);
      check("t5_empty", 32'(ow_pend_count), 32'd0);
      nxt();

      // Reset mid-operation discards pending entries without writing them.
      wb_set(1, 2, 32'h22);
      aux_set(1, 4, 32'h44);
      @(negedge iw_clk);
      nxt();
      wb_set(1, 2, 32'h23);
      aux_set(1, 4, 32'h45);
      @(negedge iw_clk);
      check("t6_pend1", 32'(ow_pend_count), 32'd1);
      nxt();
      wb_set(0, 0, 0);
      aux_set(0, 0, 0);
      iw_rst = 1'b1;
      @(negedge iw_clk);
      check("t6_rst_pend", 32'(ow_pend_count), 32'd0);
      check("t6_rst_ready", 32'(ow_aux_ready), 32'd1);
      nxt();
      iw_rst = 1'b0;
      @(negedge iw_clk);
      check("t6_post_pend", 32'(ow_pend_count), 32'd0);
      check("t6_post_we", 32'(ow_gp_write_enable), 32'd0);
      nxt();

      // Starvation: one aux entry pending under continuous WB writes.
      wb_set(1, 12, 32'h1000);
      aux_set(1, 2, 32'h5555);
      aux_q.push_back(wr_t'{5'd2, 32'h5555});
      @(negedge iw_clk);
      check("t7_stall0", 32'(ow_pipe_stall), 32'd0);
      nxt();
      aux_set(0, 0, 0);
`ifdef AMBER_WBARB_FAIR_EN
      for (int k = 1; k <= 10; k++) begin
         if (k == 9) begin
            iw_pipe_we   = 1'b1;
            iw_pipe_addr = 5'd12;
            iw_pipe_data = 32'h1009;
         end else if (k == 10) begin
            wb_set(1, 12, 32'h1009);
         end else begin
            wb_set(1, 12, 32'h1000 + k);
         end
         @(negedge iw_clk);
         check("t7_fair_stall", 32'(ow_pipe_stall), (k == 9) ? 32'd1 : 32'd0);
         check("t7_fair_pend",  32'(ow_pend_count), (k <= 9) ? 32'd1 : 32'd0);
         nxt();
      end
      wb_set(0, 0, 0);
`else
      for (int k = 1; k <= 12; k++) begin
         wb_set(1, 12, 32'h1000 + k);
         @(negedge iw_clk);
         check("t7_nostall", 32'(ow_pipe_stall), 32'd0);
         check("t7_pend", 32'(ow_pend_count), 32'd1);
         nxt();
      end
      wb_set(0, 0, 0);
      @(negedge iw_clk);
      check("t7_late_grant", 32'(ow_aux_granted), 32'd1);
      nxt();
`endif
      @(negedge iw_clk);
      check("t7_empty", 32'(ow_pend_count), 32'd0);
      nxt();

      repeat (3) nxt();
      check("left_wb_q",  32'(wb_q.size()), 32'd0);
      check("left_aux_q", 32'(aux_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
